operand_entry: RTL and testbench

Parametrised operand-entry controller for the calculator front end. It collects NUM_OPERANDS signed BCD operands of NUM_DIGITS digits each from debounced push-button pulses, using a per-digit cursor. It presents the completed operand set to the execution stage through a valid/ready handshake. It sits between the button debouncer/decoder and the arithmetic/display logic, and generalises the fixed two-operand, three-digit entry path.

---
 rtl/entry_pkg.sv | 41 ++++
 rtl/bcd_digit_cnt.sv | 29 ++
 rtl/operand_entry.sv | 168 ++++++++++++++++
 tb/tb_operand_entry.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/entry_pkg.sv
// Shared definitions for the calculator operand-entry path: BCD constants,
// one-hot entry FSM encodings, debouncer button order and button priority decode.
package entry_pkg;

    localparam int DIGIT_WIDTH = 4;
    localparam logic [DIGIT_WIDTH-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        ENTRY_IDLE = 3'b001,
        ENTRY_EDIT = 3'b010,
        ENTRY_HOLD = 3'b100
    } entry_state_t;

    // Bit order of the debouncer/decoder button bus
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_MID   = 4;
    localparam int NUM_BTNS  = 5;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT,
        ACT_MID
    } btn_act_t;

    // Only the highest-priority pressed button acts: up > down > left > right > mid
    function automatic btn_act_t decode_btn(input logic [NUM_BTNS-1:0] btns);
        if (btns[BTN_UP])         return ACT_UP;
        else if (btns[BTN_DOWN])  return ACT_DOWN;
        else if (btns[BTN_LEFT])  return ACT_LEFT;
        else if (btns[BTN_RIGHT]) return ACT_RIGHT;
        else if (btns[BTN_MID])   return ACT_MID;
        else                      return ACT_NONE;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit that steps mod 10 up or down when enabled, with synchronous clear.
module bcd_digit_cnt
    import entry_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   up,
    output logic [DIGIT_WIDTH-1:0] digit
);

    logic [DIGIT_WIDTH-1:0] digit_reg;

    // The >= compare keeps the digit inside 0..9 even from an illegal value
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            digit_reg <= '0;
        end else if (en) begin
            if (up)
                digit_reg <= (digit_reg >= BCD_MAX) ? '0 : digit_reg + 4'd1;
            else
                digit_reg <= (digit_reg == '0) ? BCD_MAX : digit_reg - 4'd1;
        end
    end

    assign digit = digit_reg;

endmodule

// File: rtl/operand_entry.sv
// Operand-entry controller: builds NUM_OPERANDS signed BCD operands from button pulses
// and offers them through a valid/ready handshake. Define ENTRY_SIGN_EN for the sign field.
module operand_entry
    import entry_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int NUM_OPERANDS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic entry_start,
    input  logic entry_abort,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_mid,
    output logic entry_busy,
    output logic [((NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1)-1:0] cur_operand,
    output logic [$clog2(NUM_DIGITS+1)-1:0]                           cur_pos,
    output logic [NUM_DIGITS*DIGIT_WIDTH-1:0]                         edit_digits,
    output logic                                                      edit_sign,
    output logic [NUM_OPERANDS*NUM_DIGITS*DIGIT_WIDTH-1:0]            ops_digits,
    output logic [NUM_OPERANDS-1:0]                                   ops_sign,
    output logic                                                      ops_valid,
    input  logic                                                      ops_ready
);

    localparam int OP_W  = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int POS_W = $clog2(NUM_DIGITS+1);
    localparam int DW    = NUM_DIGITS*DIGIT_WIDTH;
`ifdef ENTRY_SIGN_EN
    localparam logic [POS_W-1:0] TOP_POS = POS_W'(NUM_DIGITS);
`else
    localparam logic [POS_W-1:0] TOP_POS = POS_W'(NUM_DIGITS-1);
`endif
    localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPERANDS-1);

    entry_state_t state_reg, state_next;
    logic [POS_W-1:0] cur_pos_reg, cur_pos_next;
    logic [OP_W-1:0]  cur_operand_reg, cur_operand_next;
    logic [DW-1:0]    edit_digits_w;
    logic             edit_sign_reg;
    logic [NUM_OPERANDS*DW-1:0] ops_digits_reg;

    logic [NUM_BTNS-1:0] btns;
    btn_act_t act, edit_act;
    logic in_idle, in_edit, in_hold;
    logic begin_hit, abort_hit, commit, is_last, next_operand, edit_clr, step, step_up;

    assign btns[BTN_UP]    = btn_up;
    assign btns[BTN_DOWN]  = btn_down;
    assign btns[BTN_LEFT]  = btn_left;
    assign btns[BTN_RIGHT] = btn_right;
    assign btns[BTN_MID]   = btn_mid;
    assign act = decode_btn(btns);

    assign in_idle = (state_reg == ENTRY_IDLE);
    assign in_edit = (state_reg == ENTRY_EDIT);
    assign in_hold = (state_reg == ENTRY_HOLD);

    // Abort outranks every button, so buttons only act in EDIT without abort
    assign begin_hit    = in_idle && entry_start;
    assign abort_hit    = entry_abort && (in_edit || in_hold);
    assign edit_act     = (in_edit && !entry_abort) ? act : ACT_NONE;
    assign is_last      = (cur_operand_reg == LAST_OP);
    assign commit       = (edit_act == ACT_MID);
    assign next_operand = commit && !is_last;
    assign edit_clr     = begin_hit || abort_hit || next_operand;
    assign step         = (edit_act == ACT_UP) || (edit_act == ACT_DOWN);
    assign step_up      = (edit_act == ACT_UP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ENTRY_IDLE;
            cur_pos_reg     <= '0;
            cur_operand_reg <= '0;
        end else begin
            state_reg       <= state_next;
            cur_pos_reg     <= cur_pos_next;
            cur_operand_reg <= cur_operand_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cur_pos_next     = cur_pos_reg;
        cur_operand_next = cur_operand_reg;
        case (state_reg)
            ENTRY_IDLE: if (entry_start) state_next = ENTRY_EDIT;
            ENTRY_EDIT: begin
                if (entry_abort)          state_next = ENTRY_IDLE;
                else if (commit && is_last) state_next = ENTRY_HOLD;
            end
            ENTRY_HOLD: if (entry_abort || ops_ready) state_next = ENTRY_IDLE;
            default:    state_next = ENTRY_IDLE;
        endcase

        if (begin_hit || abort_hit) begin
            cur_pos_next     = '0;
            cur_operand_next = '0;
        end else if (next_operand) begin
            cur_pos_next     = '0;
            cur_operand_next = cur_operand_reg + OP_W'(1);
        end else if (edit_act == ACT_LEFT) begin
            if (cur_pos_reg < TOP_POS) cur_pos_next = cur_pos_reg + POS_W'(1);
        end else if (edit_act == ACT_RIGHT) begin
            if (cur_pos_reg != '0) cur_pos_next = cur_pos_reg - POS_W'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit_cnt u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (edit_clr),
            .en    (step && (cur_pos_reg == POS_W'(gi))),
            .up    (step_up),
            .digit (edit_digits_w[gi*DIGIT_WIDTH +: DIGIT_WIDTH])
        );
    end

`ifdef ENTRY_SIGN_EN
    logic [NUM_OPERANDS-1:0] ops_sign_reg;

    always_ff @(posedge clk) begin
        if (rst || edit_clr)
            edit_sign_reg <= 1'b0;
        else if (step && (cur_pos_reg == POS_W'(NUM_DIGITS)))
            edit_sign_reg <= ~edit_sign_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_sign_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_OPERANDS; i++)
                if (commit && (cur_operand_reg == OP_W'(i)))
                    ops_sign_reg[i] <= edit_sign_reg;
        end
    end

    assign ops_sign = ops_sign_reg;
`else
    assign edit_sign_reg = 1'b0;
    assign ops_sign      = '0;
`endif

    // Committed slots persist across abort; only reset clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_digits_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_OPERANDS; i++)
                if (commit && (cur_operand_reg == OP_W'(i)))
                    ops_digits_reg[i*DW +: DW] <= edit_digits_w;
        end
    end

    assign entry_busy  = in_edit;
    assign ops_valid   = in_hold;
    assign cur_pos     = cur_pos_reg;
    assign cur_operand = cur_operand_reg;
    assign edit_digits = edit_digits_w;
    assign edit_sign   = edit_sign_reg;
    assign ops_digits  = ops_digits_reg;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry (defaults NUM_DIGITS=3, NUM_OPERANDS=2);
// expectations follow ENTRY_SIGN_EN so the bench works in either build.
module tb_operand_entry;

`ifdef ENTRY_SIGN_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_UP    = 5'b00001;
    localparam logic [4:0] B_DOWN  = 5'b00010;
    localparam logic [4:0] B_LEFT  = 5'b00100;
    localparam logic [4:0] B_RIGHT = 5'b01000;
    localparam logic [4:0] B_MID   = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic entry_start = 1'b0, entry_abort = 1'b0, ops_ready = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_mid = 1'b0;
    logic entry_busy, edit_sign, ops_valid;
    logic [0:0]  cur_operand;
    logic [1:0]  cur_pos;
    logic [11:0] edit_digits;
    logic [23:0] ops_digits;
    logic [1:0]  ops_sign;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    operand_entry #(.NUM_DIGITS(3), .NUM_OPERANDS(2)) dut (
        .clk(clk), .rst(rst), .entry_start(entry_start), .entry_abort(entry_abort),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_mid(btn_mid), .entry_busy(entry_busy), .cur_operand(cur_operand),
        .cur_pos(cur_pos), .edit_digits(edit_digits), .edit_sign(edit_sign),
        .ops_digits(ops_digits), .ops_sign(ops_sign), .ops_valid(ops_valid),
        .ops_ready(ops_ready)
    );

    typedef struct {
        logic [4:0]  btn;
        logic        start;
        logic        abort;
        logic        ready;
        logic [1:0]  pos;
        logic        op;
        logic [11:0] dig;
        logic        sgn;
        logic        busy;
        logic        valid;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mkv(input logic [4:0] btn, input logic start, input logic [1:0] pos,
                                 input logic op, input logic [11:0] dig, input logic sgn);
        vec_t v;
        v.btn = btn; v.start = start; v.abort = 1'b0; v.ready = 1'b0;
        v.pos = pos; v.op = op; v.dig = dig; v.sgn = sgn; v.busy = 1'b1; v.valid = 1'b0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Called at a negedge: drive for one cycle, return at the next negedge
    task automatic drive(input logic [4:0] btn, input logic start, input logic abort, input logic ready);
        {btn_mid, btn_right, btn_left, btn_down, btn_up} = btn;
        entry_start = start; entry_abort = abort; ops_ready = ready;
        @(negedge clk);
        {btn_mid, btn_right, btn_left, btn_down, btn_up} = B_NONE;
        entry_start = 1'b0; entry_abort = 1'b0; ops_ready = 1'b0;
    endtask

    task automatic press(input logic [4:0] btn, input int n);
        for (int k = 0; k < n; k++) drive(btn, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_edit(input string nm, input logic [1:0] pos, input logic op,
                            input logic [11:0] dig, input logic sgn, input logic busy);
        chk({nm, ".pos"},  32'(cur_pos), 32'(pos));
        chk({nm, ".op"},   32'(cur_operand), 32'(op));
        chk({nm, ".dig"},  32'(edit_digits), 32'(dig));
        chk({nm, ".sign"}, 32'(edit_sign), 32'(sgn));
        chk({nm, ".busy"}, 32'(entry_busy), 32'(busy));
    endtask

    logic [11:0] exp0;

    initial begin
        // Reference entry from the plan: 3 up, left, down, left, 5 up, left, up, mid
        tbl[0]  = mkv(B_NONE,  1'b1, 2'd0, 1'b0, 12'h000, 1'b0);
        tbl[1]  = mkv(B_UP,    1'b0, 2'd0, 1'b0, 12'h001, 1'b0);
        tbl[2]  = mkv(B_UP,    1'b0, 2'd0, 1'b0, 12'h002, 1'b0);
        tbl[3]  = mkv(B_UP,    1'b0, 2'd0, 1'b0, 12'h003, 1'b0);
        tbl[4]  = mkv(B_LEFT,  1'b0, 2'd1, 1'b0, 12'h003, 1'b0);
        tbl[5]  = mkv(B_DOWN,  1'b0, 2'd1, 1'b0, 12'h093, 1'b0);
        tbl[6]  = mkv(B_LEFT,  1'b0, 2'd2, 1'b0, 12'h093, 1'b0);
        tbl[7]  = mkv(B_UP,    1'b0, 2'd2, 1'b0, 12'h193, 1'b0);
        tbl[8]  = mkv(B_UP,    1'b0, 2'd2, 1'b0, 12'h293, 1'b0);
        tbl[9]  = mkv(B_UP,    1'b0, 2'd2, 1'b0, 12'h393, 1'b0);
        tbl[10] = mkv(B_UP,    1'b0, 2'd2, 1'b0, 12'h493, 1'b0);
        tbl[11] = mkv(B_UP,    1'b0, 2'd2, 1'b0, 12'h593, 1'b0);
        tbl[12] = mkv(B_LEFT,  1'b0, S ? 2'd3 : 2'd2, 1'b0, 12'h593, 1'b0);
        tbl[13] = mkv(B_UP,    1'b0, S ? 2'd3 : 2'd2, 1'b0, S ? 12'h593 : 12'h693, S);
        tbl[14] = mkv(B_MID,   1'b0, 2'd0, 1'b1, 12'h000, 1'b0);
        exp0 = S ? 12'h593 : 12'h693;

        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("reset.busy",  32'(entry_busy), 0);
        chk("reset.valid", 32'(ops_valid), 0);
        chk("reset.ops",   32'(ops_digits), 0);
        chk("reset.pos",   32'(cur_pos), 0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].btn, tbl[i].start, tbl[i].abort, tbl[i].ready);
            chk_edit($sformatf("vec%0d", i), tbl[i].pos, tbl[i].op, tbl[i].dig, tbl[i].sgn, tbl[i].busy);
            chk($sformatf("vec%0d.valid", i), 32'(ops_valid), 32'(tbl[i].valid));
        end
        chk("op0.digits", 32'(ops_digits[11:0]), 32'(exp0));
        chk("op0.sign",   32'(ops_sign), 32'({1'b0, S}));

        // Operand B = 042, then hold off the consumer for four cycles
        press(B_UP, 2); press(B_LEFT, 1); press(B_UP, 4);
        chk("b.dig", 32'(edit_digits), 32'h042);
        drive(B_MID, 1'b0, 1'b0, 1'b0);
        chk("hold.valid", 32'(ops_valid), 1);
        chk("hold.busy",  32'(entry_busy), 0);
        chk("hold.ops",   32'(ops_digits), 32'({12'h042, exp0}));
        for (int i = 0; i < 4; i++) begin
            drive(B_UP | B_MID, i[0], 1'b0, 1'b0);
            chk($sformatf("hold%0d.valid", i), 32'(ops_valid), 1);
            chk($sformatf("hold%0d.ops", i), 32'(ops_digits), 32'({12'h042, exp0}));
        end
        drive(B_NONE, 1'b1, 1'b0, 1'b1);
        chk("accept.valid", 32'(ops_valid), 0);
        chk("accept.busy",  32'(entry_busy), 0);
        drive(B_NONE, 1'b0, 1'b0, 1'b0);
        chk("accept.start_ignored", 32'(entry_busy), 0);

        // Cursor saturation, simultaneous up+mid, digit wrap both ways
        drive(B_NONE, 1'b1, 1'b0, 1'b0);
        chk_edit("restart", 2'd0, 1'b0, 12'h000, 1'b0, 1'b1);
        press(B_LEFT, 6);
        chk("sat.pos", 32'(cur_pos), S ? 32'd3 : 32'd2);
        drive(B_UP | B_MID, 1'b0, 1'b0, 1'b0);
        chk_edit("upmid", S ? 2'd3 : 2'd2, 1'b0, S ? 12'h000 : 12'h100, S, 1'b1);
        chk("upmid.ops0", 32'(ops_digits[11:0]), 32'(exp0));
        press(B_RIGHT, 6);
        chk("right.sat", 32'(cur_pos), 0);
        press(B_DOWN, 1);
        chk("wrap.down", 32'(edit_digits), S ? 32'h009 : 32'h109);
        press(B_UP, 1);
        chk("wrap.up", 32'(edit_digits), S ? 32'h000 : 32'h100);

        // Commit (negative zero in the sign build), then abort while editing operand 1
        drive(B_MID, 1'b0, 1'b0, 1'b0);
        chk("negz.ops0",  32'(ops_digits[11:0]), S ? 32'h000 : 32'h100);
        chk("negz.sign0", 32'(ops_sign), 32'({1'b0, S}));
        chk("negz.op",    32'(cur_operand), 1);
        press(B_UP, 1);
        drive(B_UP, 1'b0, 1'b1, 1'b0);
        chk_edit("abort_edit", 2'd0, 1'b0, 12'h000, 1'b0, 1'b0);
        chk("abort_edit.valid", 32'(ops_valid), 0);
        chk("abort_edit.ops", 32'(ops_digits), 32'({12'h042, S ? 12'h000 : 12'h100}));

        // Abort in HOLD outranks ops_ready
        drive(B_NONE, 1'b1, 1'b0, 1'b0);
        drive(B_MID, 1'b0, 1'b0, 1'b0);
        press(B_UP, 1);
        drive(B_MID, 1'b0, 1'b0, 1'b0);
        chk("hold2.valid", 32'(ops_valid), 1);
        drive(B_NONE, 1'b0, 1'b1, 1'b1);
        chk_edit("abort_hold", 2'd0, 1'b0, 12'h000, 1'b0, 1'b0);
        chk("abort_hold.valid", 32'(ops_valid), 0);
        chk("abort_hold.ops", 32'(ops_digits), 32'h001000);
        chk("abort_hold.sign", 32'(ops_sign), 0);

        // Reset in EDIT with non-zero digits
        drive(B_NONE, 1'b1, 1'b0, 1'b0);
        press(B_UP, 2); press(B_LEFT, 1); press(B_UP, 1);
        chk("pre_rst.dig", 32'(edit_digits), 32'h012);
        rst = 1'b1;
        drive(B_UP, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk_edit("rst", 2'd0, 1'b0, 12'h000, 1'b0, 1'b0);
        chk("rst.valid", 32'(ops_valid), 0);
        chk("rst.ops",   32'(ops_digits), 0);
        chk("rst.sign",  32'(ops_sign), 0);

        // Cursor range and sign tie-off for the current build
        drive(B_NONE, 1'b1, 1'b0, 1'b0);
        press(B_LEFT, 5);
        chk("range.pos", 32'(cur_pos), S ? 32'd3 : 32'd2);
        press(B_UP, 1);
        chk("range.esign", 32'(edit_sign), 32'(S));
        chk("range.dig", 32'(edit_digits), S ? 32'h000 : 32'h100);
        drive(B_MID, 1'b0, 1'b0, 1'b0);
        chk("range.ops_sign", 32'(ops_sign), 32'({1'b0, S}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
